addsub_nibble_seq: RTL

Multi-cycle wide add/subtract front-end that widens the team's 4-bit add/subtract datapath to NIBBLES*4 bits. It processes one nibble per clock through a 4-bit add/sub slice (A + (B xor {4{M}}) + Cin), carrying between nibbles in a register. It accepts full-width operands from the upstream operand/control logic with a start/busy/done handshake. It delivers registered sum, carry/borrow, signed-overflow and zero flags to the downstream result/display stage.

---
 rtl/addsub_nibble_seq.sv | 117 +++++++++++
 1 files changed

// File: rtl/addsub_nibble_seq.sv
// Wide add/subtract built from a single 4-bit slice, one nibble per clock.
// Operands are captured on start; flags and sum are published only when the last nibble completes.
module addsub_nibble_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   m,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   s,
    output logic                   c,
    output logic                   v,
    output logic                   z
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] DONE_ST = 2'd2;

    logic [1:0]    state;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic          m_r;
    logic [W-1:0]  work;
    logic [CW-1:0] cnt;
    logic          carry;

    logic [3:0]    nib_a;
    logic [3:0]    nib_b;
    logic [4:0]    sum5;
    logic [W-1:0]  mask;
    logic [W-1:0]  ins;
    logic [W-1:0]  work_next;
    logic          last;
    logic          carry_msb;

    // Nibble slice: select nibble cnt, add, and splice the result into the working word
    always_comb begin
        nib_a     = 4'(a_r >> {cnt, 2'b00});
        nib_b     = 4'(b_r >> {cnt, 2'b00}) ^ {4{m_r}};
        sum5      = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry};
        mask      = {{(W-4){1'b0}}, 4'hF} << {cnt, 2'b00};
        ins       = {{(W-4){1'b0}}, sum5[3:0]} << {cnt, 2'b00};
        work_next = (work & ~mask) | ins;
        last      = (cnt == LAST);
        // Carry into the MSB recovered from the MSB sum bit, used only on the last nibble
        carry_msb = a_r[W-1] ^ b_r[W-1] ^ m_r ^ sum5[3];
    end

    // Sequencer, operand capture and registered result/flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            m_r   <= 1'b0;
            work  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            c     <= 1'b0;
            v     <= 1'b0;
            z     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        m_r   <= m;
                        cnt   <= '0;
                        carry <= m;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    work  <= work_next;
                    carry <= sum5[4];
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        s     <= work_next;
                        c     <= sum5[4];
                        v     <= carry_msb ^ sum5[4];
                        z     <= (work_next == '0);
                        done  <= 1'b1;
                        state <= DONE_ST;
                    end
                end
                DONE_ST: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
